// File: rtl/or1k_bus_pkg.sv
// Shared types and constants for the OR1K instruction/data bus arbiter.
package or1k_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    localparam logic MASTER_I = 1'b0;
    localparam logic MASTER_D = 1'b1;

    localparam logic [31:0] TO_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/or1k_bus_watchdog.sv
// Per-transaction ack watchdog: a down-counter armed on grant entry, with a
// timeout pulse on terminal count and a saturating timeout event counter.
module or1k_bus_watchdog #(
    parameter int TO_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       en,
    input  logic       ack,
    output logic       tmo,
    output logic [7:0] to_cnt
);

    // Grant-entry cycle counts as the first of 2**TO_W-1 grant cycles, so the
    // counter lands on zero in the last allowed cycle.
    localparam logic [TO_W-1:0] ALL_ONES = '1;
    localparam logic [TO_W-1:0] LOAD     = ALL_ONES - TO_W'(1);

    logic [TO_W-1:0] wd_q;

    assign tmo = en && (wd_q == '0) && !ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            to_cnt <= '0;
        end else begin
            if (start) begin
                wd_q <= LOAD;
            end else if (!en) begin
                wd_q <= '0;
            end else if (wd_q != '0) begin
                wd_q <= wd_q - TO_W'(1);
            end

            if (tmo && (to_cnt != 8'hFF)) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/or1k_bus_arbiter.sv
// Merges the OR1K instruction and data buses onto one memory port with
// data-first priority, instruction anti-starvation, and an ack watchdog.
//
// state   | meaning
// IDLE    | no transaction; grant decision made this cycle
// GRANT_I | instruction master owns mem_*, waiting for mem_ack or timeout
// GRANT_D | data master owns mem_*, waiting for mem_ack or timeout
module or1k_bus_arbiter
    import or1k_bus_pkg::*;
#(
    parameter int          AW        = 24,
    parameter int          MAX_D_RUN = 4,
    parameter int          TO_W      = 8,
    parameter logic [31:0] TO_DATA   = TO_DATA_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icpu_cs,
    input  logic          icpu_we,
    input  logic [3:0]    icpu_sel,
    input  logic [AW-1:0] icpu_adr,
    input  logic [31:0]   icpu_dat_w,
    output logic [31:0]   icpu_dat_r,
    output logic          icpu_ack,
    input  logic          dcpu_cs,
    input  logic          dcpu_we,
    input  logic [3:0]    dcpu_sel,
    input  logic [AW-1:0] dcpu_adr,
    input  logic [31:0]   dcpu_dat_w,
    output logic [31:0]   dcpu_dat_r,
    output logic          dcpu_ack,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [3:0]    mem_sel,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_dat_w,
    input  logic [31:0]   mem_dat_r,
    input  logic          mem_ack,
    output logic          to_err,
    output logic [7:0]    to_cnt
);

    localparam logic [3:0] D_RUN_MAX = 4'(MAX_D_RUN);

    arb_state_e  state_q, state_d;
    logic [3:0]  d_run_q;
    logic        grant_i, grant_d, in_grant, done, tmo;
    logic        sel_master;
    logic [31:0] ack_data, icpu_dat_q, dcpu_dat_q;

    assign in_grant   = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign done       = in_grant && (mem_ack || tmo);
    assign sel_master = grant_d ? MASTER_D : MASTER_I;
    assign ack_data   = mem_ack ? mem_dat_r : TO_DATA;
    assign to_err     = tmo;

    always_comb begin
        state_d  = state_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        icpu_ack = 1'b0;
        dcpu_ack = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins unless the instruction side has waited out a full run.
                if (dcpu_cs && !(icpu_cs && (d_run_q == D_RUN_MAX))) begin
                    grant_d = 1'b1;
                    state_d = GRANT_D;
                end else if (icpu_cs) begin
                    grant_i = 1'b1;
                    state_d = GRANT_I;
                end
            end
            GRANT_I: begin
                if (done) begin
                    icpu_ack = 1'b1;
                    state_d  = IDLE;
                end
            end
            GRANT_D: begin
                if (done) begin
                    dcpu_ack = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign icpu_dat_r = icpu_ack ? ack_data : icpu_dat_q;
    assign dcpu_dat_r = dcpu_ack ? ack_data : dcpu_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            d_run_q    <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= '0;
            mem_adr    <= '0;
            mem_dat_w  <= '0;
            icpu_dat_q <= '0;
            dcpu_dat_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant_i) begin
                d_run_q <= '0;
            end else if (grant_d && (d_run_q != D_RUN_MAX)) begin
                d_run_q <= d_run_q + 4'd1;
            end

            if (grant_i || grant_d) begin
                mem_cs <= 1'b1;
                if (sel_master == MASTER_D) begin
                    mem_we    <= dcpu_we;
                    mem_sel   <= dcpu_sel;
                    mem_adr   <= dcpu_adr;
                    mem_dat_w <= dcpu_dat_w;
                end else begin
                    mem_we    <= icpu_we;
                    mem_sel   <= icpu_sel;
                    mem_adr   <= icpu_adr;
                    mem_dat_w <= icpu_dat_w;
                end
            end else if (done) begin
                mem_cs <= 1'b0;
            end

            if (icpu_ack) icpu_dat_q <= ack_data;
            if (dcpu_ack) dcpu_dat_q <= ack_data;
        end
    end

    or1k_bus_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (grant_i || grant_d),
        .en     (in_grant),
        .ack    (mem_ack),
        .tmo    (tmo),
        .to_cnt (to_cnt)
    );

endmodule

// File: tb/tb_or1k_bus_arbiter.sv
// Directed bench for or1k_bus_arbiter: per-cycle vector table plus sequences
// for starvation, timeout, ack/timeout coincidence and reset mid-grant.
module tb_or1k_bus_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          icpu_cs, icpu_we, dcpu_cs, dcpu_we, mem_ack;
    logic [3:0]    icpu_sel, dcpu_sel, mem_sel;
    logic [AW-1:0] icpu_adr, dcpu_adr, mem_adr;
    logic [31:0]   icpu_dat_w, dcpu_dat_w, icpu_dat_r, dcpu_dat_r;
    logic [31:0]   mem_dat_w, mem_dat_r;
    logic          icpu_ack, dcpu_ack, mem_cs, mem_we, to_err;
    logic [7:0]    to_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    or1k_bus_arbiter #(
        .AW        (AW),
        .MAX_D_RUN (4),
        .TO_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .icpu_cs    (icpu_cs),
        .icpu_we    (icpu_we),
        .icpu_sel   (icpu_sel),
        .icpu_adr   (icpu_adr),
        .icpu_dat_w (icpu_dat_w),
        .icpu_dat_r (icpu_dat_r),
        .icpu_ack   (icpu_ack),
        .dcpu_cs    (dcpu_cs),
        .dcpu_we    (dcpu_we),
        .dcpu_sel   (dcpu_sel),
        .dcpu_adr   (dcpu_adr),
        .dcpu_dat_w (dcpu_dat_w),
        .dcpu_dat_r (dcpu_dat_r),
        .dcpu_ack   (dcpu_ack),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .mem_adr    (mem_adr),
        .mem_dat_w  (mem_dat_w),
        .mem_dat_r  (mem_dat_r),
        .mem_ack    (mem_ack),
        .to_err     (to_err),
        .to_cnt     (to_cnt)
    );

    typedef struct {
        logic        i_cs;
        logic        d_cs;
        logic        m_ack;
        logic [31:0] m_dat;
        logic        e_mcs;
        logic [31:0] e_adr;
        logic        e_we;
        logic        e_iack;
        logic        e_dack;
        logic [31:0] e_idat;
        logic [31:0] e_ddat;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic i, input logic d, input logic a,
                                input logic [31:0] md, input logic mcs,
                                input logic [31:0] adr, input logic we,
                                input logic ia, input logic da,
                                input logic [31:0] idat, input logic [31:0] ddat);
        vec_t v;
        v.i_cs = i;   v.d_cs = d;   v.m_ack = a;   v.m_dat = md;
        v.e_mcs = mcs; v.e_adr = adr; v.e_we = we;
        v.e_iack = ia; v.e_dack = da; v.e_idat = idat; v.e_ddat = ddat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        icpu_cs   = 1'b0;
        dcpu_cs   = 1'b0;
        mem_ack   = 1'b0;
        mem_dat_r = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n, found, early, adr_bad;
        logic [9:0] seq;

        icpu_we = 1'b0; icpu_sel = 4'hF; icpu_adr = 24'h000200; icpu_dat_w = 32'h1111_1111;
        dcpu_we = 1'b1; dcpu_sel = 4'h3; dcpu_adr = 24'h000100; dcpu_dat_w = 32'hD0D0_D0D0;

        //                i  d  ack md            mcs adr         we ia da idat          ddat
        vecs[0]  = mk(0, 1, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,         1, 32'h100,    1, 0, 0, 32'h0,         32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,         1, 32'h100,    1, 0, 0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 1, 1, 32'h12345678,  1, 32'h100,    1, 0, 1, 32'h0,         32'h12345678);
        vecs[4]  = mk(0, 0, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'h0,         32'h12345678);
        vecs[5]  = mk(0, 0, 1, 32'hDEAD0000,  0, 32'h0,      0, 0, 0, 32'h0,         32'h12345678);
        vecs[6]  = mk(1, 1, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'h0,         32'h12345678);
        vecs[7]  = mk(1, 1, 0, 32'h0,         1, 32'h100,    1, 0, 0, 32'h0,         32'h12345678);
        vecs[8]  = mk(1, 1, 1, 32'hAAAA0001,  1, 32'h100,    1, 0, 1, 32'h0,         32'hAAAA0001);
        vecs[9]  = mk(1, 0, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'h0,         32'hAAAA0001);
        vecs[10] = mk(1, 0, 0, 32'h0,         1, 32'h200,    0, 0, 0, 32'h0,         32'hAAAA0001);
        vecs[11] = mk(1, 0, 1, 32'hBBBB0002,  1, 32'h200,    0, 1, 0, 32'hBBBB0002,  32'hAAAA0001);
        vecs[12] = mk(0, 0, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'hBBBB0002,  32'hAAAA0001);
        vecs[13] = mk(0, 1, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'hBBBB0002,  32'hAAAA0001);
        vecs[14] = mk(0, 0, 0, 32'h0,         1, 32'h100,    1, 0, 0, 32'hBBBB0002,  32'hAAAA0001);
        vecs[15] = mk(0, 0, 1, 32'h00000055,  1, 32'h100,    1, 0, 1, 32'hBBBB0002,  32'h00000055);
        vecs[16] = mk(0, 0, 0, 32'h0,         0, 32'h0,      0, 0, 0, 32'hBBBB0002,  32'h00000055);

        do_reset();
        chk("reset mem_cs", {31'h0, mem_cs}, 32'h0);
        chk("reset mem_adr", {8'h0, mem_adr}, 32'h0);
        chk("reset mem_dat_w", mem_dat_w, 32'h0);
        chk("reset acks", {30'h0, icpu_ack, dcpu_ack}, 32'h0);
        chk("reset dat_r", icpu_dat_r | dcpu_dat_r, 32'h0);
        chk("reset to_cnt", {24'h0, to_cnt}, 32'h0);

        // Single read, simultaneous requests, stray ack, cs dropped mid-grant.
        for (int i = 0; i < 17; i++) begin
            icpu_cs   = vecs[i].i_cs;
            dcpu_cs   = vecs[i].d_cs;
            mem_ack   = vecs[i].m_ack;
            mem_dat_r = vecs[i].m_dat;
            #1;
            chk($sformatf("v%0d mem_cs", i), {31'h0, mem_cs}, {31'h0, vecs[i].e_mcs});
            if (vecs[i].e_mcs) begin
                chk($sformatf("v%0d mem_adr", i), {8'h0, mem_adr}, vecs[i].e_adr);
                chk($sformatf("v%0d mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].e_we});
            end
            chk($sformatf("v%0d icpu_ack", i), {31'h0, icpu_ack}, {31'h0, vecs[i].e_iack});
            chk($sformatf("v%0d dcpu_ack", i), {31'h0, dcpu_ack}, {31'h0, vecs[i].e_dack});
            chk($sformatf("v%0d icpu_dat_r", i), icpu_dat_r, vecs[i].e_idat);
            chk($sformatf("v%0d dcpu_dat_r", i), dcpu_dat_r, vecs[i].e_ddat);
            step();
        end
        mem_ack = 1'b0;

        // Starvation: both requests held, memory acks in the first grant cycle.
        do_reset();
        icpu_cs = 1'b1;
        dcpu_cs = 1'b1;
        n = 0; seq = '0; adr_bad = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            mem_ack   = mem_cs;
            mem_dat_r = 32'h0000_1000 + 32'(c);
            #1;
            if (dcpu_ack || icpu_ack) begin
                seq = {seq[8:0], dcpu_ack};
                if (mem_adr != (dcpu_ack ? 24'h000100 : 24'h000200)) adr_bad++;
                n++;
            end
            step();
        end
        icpu_cs = 1'b0; dcpu_cs = 1'b0; mem_ack = 1'b0;
        chk("starve grant count", 32'(n), 32'd10);
        chk("starve grant order", {22'h0, seq}, {22'h0, 10'b1111011110});
        chk("starve mem_adr per grant", 32'(adr_bad), 32'd0);
        step();

        // Timeout: no mem_ack; master inputs changing after latch must not leak.
        do_reset();
        dcpu_cs = 1'b1;
        step();
        dcpu_cs   = 1'b0;
        dcpu_adr  = 24'h0003FF;
        mem_dat_r = 32'hCAFE_0000;
        found = 0; adr_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (mem_cs && mem_adr != 24'h000100) adr_bad++;
            if (dcpu_ack) begin
                found = k;
                chk("timeout dcpu_dat_r", dcpu_dat_r, 32'h0);
                chk("timeout to_err", {31'h0, to_err}, 32'h1);
                chk("timeout icpu_ack", {31'h0, icpu_ack}, 32'h0);
                break;
            end
            step();
        end
        chk("timeout grant cycle", 32'(found), 32'd15);
        chk("timeout mem_adr held", 32'(adr_bad), 32'd0);
        step();
        chk("timeout mem_cs after", {31'h0, mem_cs}, 32'h0);
        chk("timeout to_err after", {31'h0, to_err}, 32'h0);
        chk("timeout to_cnt", {24'h0, to_cnt}, 32'd1);
        dcpu_adr = 24'h000100;

        // mem_ack on the last allowed cycle: ack wins over timeout.
        dcpu_cs = 1'b1;
        step();
        dcpu_cs = 1'b0;
        early = 0;
        for (int k = 1; k <= 14; k++) begin
            #1;
            if (dcpu_ack || to_err) early++;
            step();
        end
        chk("coincide early ack", 32'(early), 32'd0);
        mem_ack   = 1'b1;
        mem_dat_r = 32'h600D_F00D;
        #1;
        chk("coincide dcpu_ack", {31'h0, dcpu_ack}, 32'h1);
        chk("coincide dcpu_dat_r", dcpu_dat_r, 32'h600D_F00D);
        chk("coincide to_err", {31'h0, to_err}, 32'h0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("coincide to_cnt", {24'h0, to_cnt}, 32'd1);
        chk("coincide mem_cs after", {31'h0, mem_cs}, 32'h0);
        step();

        // Reset asserted mid-grant, then a fresh request.
        icpu_cs = 1'b1;
        step();
        icpu_cs = 1'b0;
        chk("rst-mid mem_cs before", {31'h0, mem_cs}, 32'h1);
        #2;
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rst-mid mem_cs", {31'h0, mem_cs}, 32'h0);
        chk("rst-mid icpu_ack", {31'h0, icpu_ack}, 32'h0);
        chk("rst-mid to_cnt", {24'h0, to_cnt}, 32'h0);
        mem_ack = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        icpu_cs = 1'b1;
        #1;
        chk("post-rst idle mem_cs", {31'h0, mem_cs}, 32'h0);
        step();
        chk("post-rst mem_cs", {31'h0, mem_cs}, 32'h1);
        chk("post-rst mem_adr", {8'h0, mem_adr}, 32'h200);
        mem_ack   = 1'b1;
        mem_dat_r = 32'h0BAD_CAFE;
        #1;
        chk("post-rst icpu_ack", {31'h0, icpu_ack}, 32'h1);
        chk("post-rst icpu_dat_r", icpu_dat_r, 32'h0BAD_CAFE);
        step();
        mem_ack = 1'b0;
        icpu_cs = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or1k_bus_arbiter.md
Name: or1k_bus_arbiter

Overview:
- Sits directly downstream of the OR1K CPU wrapper.
- Merges the CPU's separate instruction (icpu_*) and data (dcpu_*) chip-select buses onto one shared memory-side port (mem_*).
- Provides data-first priority with an instruction anti-starvation limit.
- Provides a per-transaction ack watchdog, so a dead slave can never hang the CPU.

Parameters:
AW, 24, address width of all address ports
MAX_D_RUN, 4, max consecutive data grants while an instruction request is pending (1..15)
TO_W, 8, width of watchdog counter; timeout after 2**TO_W-1 cycles in a grant state
TO_DATA, 32'h0000_0000, read data returned to the master on timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
icpu_cs  in  1  instruction request (held until ack seen)
icpu_we  in  1  instruction write enable
icpu_sel  in  4  instruction byte selects
icpu_adr  in  AW  instruction address
icpu_dat_w  in  32  instruction write data
icpu_dat_r  out  32  instruction read data
icpu_ack  out  1  instruction ack, one-cycle pulse
dcpu_cs  in  1  data request
dcpu_we  in  1  data write enable
dcpu_sel  in  4  data byte selects
dcpu_adr  in  AW  data address
dcpu_dat_w  in  32  data write data
dcpu_dat_r  out  32  data read data
dcpu_ack  out  1  data ack, one-cycle pulse
mem_cs  out  1  memory request
mem_we  out  1  memory write enable
mem_sel  out  4  memory byte selects
mem_adr  out  AW  memory address
mem_dat_w  out  32  memory write data
mem_dat_r  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory ack, one-cycle pulse
to_err  out  1  one-cycle pulse on watchdog timeout
to_cnt  out  8  saturating count of timeouts

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; mem_cs, mem_we, mem_sel, mem_adr, mem_dat_w = 0.
  - d_run=0, wd=0, to_err=0, to_cnt=0.
  - icpu_ack=dcpu_ack=0; icpu_dat_r=dcpu_dat_r=0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE grant decision:
  - dcpu_cs & !(icpu_cs & d_run==MAX_D_RUN) -> GRANT_D, d_run+=1 (saturating at MAX_D_RUN).
  - else icpu_cs -> GRANT_I, d_run=0.
  - else stay in IDLE.
  - In the starvation case (d_run==MAX_D_RUN with both requests pending), GRANT_I wins.
  - Any instruction grant clears d_run. A data grant with no instruction request pending does not clear d_run.
- Grant entry: on the IDLE->GRANT edge, mem_cs=1 and mem_we/sel/adr/dat_w are registered from the selected master. Latency from request to mem_cs is 1 cycle.
- Hold: mem_* are held constant for the whole grant, and master inputs are ignored after latching.
- Grant completion on mem_ack=1:
  - Same cycle, combinationally: granted master's *_ack=1 and its *_dat_r=mem_dat_r.
  - Next edge: mem_cs=0, state=IDLE, wd=0.
- Non-granted master: ack=0; dat_r holds its last registered value (the dat_r outputs are captured registers; ack is combinational).
- Watchdog: wd counts every cycle in a grant state. When wd==2**TO_W-1 and mem_ack=0:
  - Granted master gets *_ack=1 and *_dat_r=TO_DATA.
  - to_err=1 for one cycle; to_cnt+=1 (saturates at 255).
  - Next edge: mem_cs=0, state=IDLE.
- mem_ack and timeout in the same cycle: ack wins; no to_err, no count.
- mem_ack while in IDLE (stray): ignored, no master ack.
- Master cs deasserted mid-grant: no abort; the transaction completes on the memory side and the ack is still issued. The master's wrapper tolerates this.
- Back-to-back timing: the master drops cs the cycle after ack, and the arbiter is in IDLE that cycle. There is no dead-cycle requirement beyond the 1-cycle IDLE pass.
- Reset mid-grant: mem_cs drops immediately (async), and no ack is generated.

Decomposition:
- Shared package or1k_bus_pkg:
  - State encoding enum (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2).
  - MASTER_I/MASTER_D constants.
  - Default TO_DATA.
- Sub-module or1k_bus_watchdog: counter with clear/enable inputs and a timeout pulse output, plus the saturating to_cnt. Reusable for other bus masters.

Test Plan:
- Single data read: dcpu_cs=1, adr=0x000100; mem_ack at cycle 3 with dat_r=0x12345678 -> mem_cs high cycles 1..3; dcpu_ack pulse at cycle 3 with dcpu_dat_r=0x12345678; icpu_ack never set.
- Simultaneous requests: icpu_cs and dcpu_cs both high at cycle 0 -> data granted first; instruction granted in the IDLE pass after the data ack.
- Starvation: dcpu_cs re-requests continuously, icpu_cs held, MAX_D_RUN=4 -> exactly 4 data grants, then 1 instruction grant, then data resumes.
- Timeout: TO_W=4, dcpu_cs with no mem_ack -> at the 15th grant cycle dcpu_ack=1, dcpu_dat_r=0, to_err pulse, to_cnt=1, mem_cs low the next cycle.
- Ack/timeout coincide: mem_ack at wd=15 with TO_W=4 -> normal ack with mem_dat_r; to_err=0; to_cnt unchanged.
- Reset mid-grant: rst_n low during GRANT_I -> mem_cs=0 asynchronously, no icpu_ack; after release, a fresh request is granted with 1-cycle latency.
